serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/fulladder.sv | 13 +
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Holds the FSM state encodings and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/fulladder.sv
// Existing 1-bit full-adder leaf cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell processes one bit per cycle, LSB first,
// behind a start/done valid-ready handshake. Latency is exactly WIDTH cycles.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    fulladder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign busy     = (state != IDLE);
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // reset gates the handshakes so it wins over any accept/retire in the same cycle
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                start_ready = !rst;
                if (start_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_valid = !rst;
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // subtraction is a + ~b + 1, so the operand is inverted and the carry seeded at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            s     <= {fa_s, s[WIDTH-1:1]};
            carry <= fa_co;
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                co  <= fa_co;
                ovf <= carry ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed vectors, queued expectations,
// and a monitor that checks every retired result and the accept-to-done latency.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         done_valid;
    logic         done_ready = 1'b1;
    logic         busy;

    res_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = -1000;
    int   res_idx = 0;
    logic prev_dv = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .ci          (ci),
        .sub         (sub),
        .s           (s),
        .co          (co),
        .ovf         (ovf),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: records accept edges, checks latency at the rising done_valid, scores retirements.
    always @(negedge clk) begin
        res_t e;
        if (!rst && start_valid && start_ready) acc_cyc = cyc + 1;
        if (done_valid && !prev_dv) check($sformatf("latency_r%0d", res_idx), cyc - acc_cyc, W);
        if (done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=s:0x%0h required=no_result", s);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("s_r%0d", res_idx), s, e.s);
                check($sformatf("co_r%0d", res_idx), co, e.co);
                check($sformatf("ovf_r%0d", res_idx), ovf, e.ovf);
            end
            res_idx++;
        end
        prev_dv = done_valid;
    end

    task automatic push_exp(input logic [W-1:0] es, input logic eco, input logic eovf);
        res_t r;
        r.s   = es;
        r.co  = eco;
        r.ovf = eovf;
        exp_q.push_back(r);
    endtask

    // Presents one operation and returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                         input logic tsub, input logic push, input logic [W-1:0] es,
                         input logic eco, input logic eovf);
        int n;
        @(posedge clk);
        #1;
        a = ta; b = tb_v; ci = tci; sub = tsub;
        start_valid = 1'b1;
        if (push) push_exp(es, eco, eovf);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (start_ready) break;
        end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=start_ready:0 required=1");
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        if (n == 100) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=pending:%0d required=0", exp_q.size());
        end
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done_valid) break;
        end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=done_valid:0 required=1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_ovf", ovf, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_start_ready", start_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_start_ready", start_ready, 1);

        // Directed arithmetic vectors
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1); wait_drain();
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0); wait_drain();
        issue(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0); wait_drain();
        issue(8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0); wait_drain();
        issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1); wait_drain();
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1); wait_drain();
        issue(8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0); wait_drain();

        // Backpressure in DONE with an ignored start pulse
        done_ready = 1'b0;
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start_valid = (i == 2);
            a = 8'h11; b = 8'h22; ci = 1'b1; sub = 1'b0;
            @(negedge clk);
            check($sformatf("bp_s_%0d", i), s, 8'h96);
            check($sformatf("bp_co_%0d", i), co, 0);
            check($sformatf("bp_ovf_%0d", i), ovf, 1);
            check($sformatf("bp_done_valid_%0d", i), done_valid, 1);
            check($sformatf("bp_start_ready_%0d", i), start_ready, 0);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_start_ready", start_ready, 1);
        check("bp_release_busy", busy, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_valid || busy) seen = 1'b1;
        end
        check("bp_ignored_start", seen, 0);

        // Reset in the middle of a run, at bit 3
        issue(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_s", s, 0);
        check("abort_co", co, 0);
        check("abort_ovf", ovf, 0);
        check("abort_done_valid", done_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_start_ready", start_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_valid) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0); wait_drain();

        // Back-to-back: start_valid held across the DONE handshake
        push_exp(8'hFF, 1'b1, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; ci = 1'b1; sub = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        a = 8'h7F; b = 8'h80; ci = 1'b0; sub = 1'b1;
        wait_done();
        @(negedge clk);
        check("b2b_first_idle_ready", start_ready, 1);
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_accepted", busy, 1);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
